// File: rtl/utmi_rx_pkg.sv
// rtl/utmi_rx_pkg.sv - shared state encoding and constants for the UTMI RX unstuffer/deserializer
package utmi_rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rx_state_t;

  localparam int STUFF_LEN_DEF      = 6;
  localparam int SYNC_MIN_ZEROS_DEF = 3;
  // Consecutive 1s that mark the line as idle again after a packet.
  localparam int EOP_ONES           = 7;
  localparam int BYTE_W             = 8;

endpackage

// File: rtl/utmi_rx_bit_unstuffer.sv
// rtl/utmi_rx_bit_unstuffer.sv - tracks runs of 1s, flags stuffed bits and stuff violations
module utmi_rx_bit_unstuffer
  import utmi_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       strobe,
  input  logic       clear,
  output logic       data_bit,
  output logic       data_strobe,
  output logic       stuff_err,
  output logic [2:0] ones_cnt
);

  logic stuff_slot;

  // The bit following a full run of 1s is the stuff slot: a 0 there is dropped,
  // a 1 there is a violation (EOP or error, decided by the caller).
  assign stuff_slot  = (ones_cnt == 3'(STUFF_LEN));
  assign data_bit    = in_bit;
  assign data_strobe = strobe && !stuff_slot;
  assign stuff_err   = strobe && stuff_slot && in_bit;

  // Saturating count of consecutive 1s; stuffed 0s break the run like any 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (strobe) begin
      if (!in_bit) begin
        ones_cnt <= '0;
      end else if (ones_cnt != 3'd7) begin
        ones_cnt <= ones_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/utmi_rx_unstuff_deser.sv
// rtl/utmi_rx_unstuff_deser.sv - SYNC hunt, bit unstuffing and LSB-first byte deserializer; UTMI_RX_BYTE_CNT_EN adds rx_byte_count
module utmi_rx_unstuff_deser
  import utmi_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int STUFF_LEN      = STUFF_LEN_DEF,
  parameter int MAX_BYTES      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  input  logic        data_en,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  output logic        RX_ACTIVE,
  output logic        RX_ERROR
`ifdef UTMI_RX_BYTE_CNT_EN
  ,
  output logic [15:0] rx_byte_count
`endif
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  rx_state_t          state, state_d;
  logic [2:0]         zero_cnt;
  logic [2:0]         bit_cnt;
  logic [BYTE_W-1:0]  shift;
  logic [BYTE_W-1:0]  shift_next;
  logic [BCW-1:0]     byte_cnt;

  logic               clear;
  logic               d_bit;
  logic               d_strobe;
  logic               stuff_err;
  logic [2:0]         ones_cnt;

  logic               sync_hit;
  logic               data_take;
  logic               byte_done;
  logic               babble;
  logic               byte_ok;
  logic               eop_err;
  logic               go_done;

  utmi_rx_bit_unstuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuffer (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (data_in),
    .strobe      (data_en),
    .clear       (clear),
    .data_bit    (d_bit),
    .data_strobe (d_strobe),
    .stuff_err   (stuff_err),
    .ones_cnt    (ones_cnt)
  );

  // New bits enter at the top so the first bit received ends up in bit 0.
  assign shift_next = {d_bit, shift[BYTE_W-1:1]};
  assign byte_ok    = byte_done && !babble;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and event decode; the run counter is held clear outside DATA/DONE
  // and restarted on entry to DONE so the idle check counts fresh 1s.
  always_comb begin
    state_d   = state;
    clear     = 1'b0;
    sync_hit  = 1'b0;
    data_take = 1'b0;
    byte_done = 1'b0;
    babble    = 1'b0;
    eop_err   = 1'b0;
    go_done   = 1'b0;
    case (state)
      HUNT: begin
        clear = 1'b1;
        if (data_en && !data_in) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        clear = 1'b1;
        if (data_en && data_in) begin
          if (int'(zero_cnt) >= SYNC_MIN_ZEROS) begin
            state_d  = DATA;
            sync_hit = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
      end
      DATA: begin
        if (stuff_err) begin
          go_done = 1'b1;
          eop_err = (bit_cnt != 3'd7);
        end else if (d_strobe) begin
          data_take = 1'b1;
          byte_done = (bit_cnt == 3'd7);
          babble    = byte_done && (byte_cnt == BCW'(MAX_BYTES));
          go_done   = babble;
        end
        if (go_done) begin
          state_d = DONE;
          clear   = 1'b1;
        end
      end
      DONE: begin
        if (data_en && data_in && (int'(ones_cnt) >= EOP_ONES - 1)) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Shifter, counters and the registered SIE-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_cnt  <= '0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      RX_ACTIVE <= 1'b0;
      RX_ERROR  <= 1'b0;
    end else begin
      RX_VALID <= byte_ok;
      RX_ERROR <= eop_err || babble;

      if (state == HUNT && data_en && !data_in) begin
        zero_cnt <= 3'd1;
      end else if (state == SYNC && data_en && !data_in && zero_cnt != 3'd7) begin
        zero_cnt <= zero_cnt + 3'd1;
      end

      if (sync_hit) begin
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        RX_ACTIVE <= 1'b1;
      end

      if (data_take) begin
        shift   <= shift_next;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_ok) begin
        RX_DATA  <= shift_next;
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (go_done) begin
        RX_ACTIVE <= 1'b0;
      end
    end
  end

`ifdef UTMI_RX_BYTE_CNT_EN
  // Visible byte count: cleared at SYNC, frozen once the packet ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_count <= '0;
    end else if (sync_hit) begin
      rx_byte_count <= '0;
    end else if (byte_ok) begin
      rx_byte_count <= rx_byte_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_utmi_rx_unstuff_deser.sv
// tb/tb_utmi_rx_unstuff_deser.sv - scoreboard bench for utmi_rx_unstuff_deser
module tb_utmi_rx_unstuff_deser;

  localparam int MAXB = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       data_en;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ACTIVE;
  logic       RX_ERROR;
`ifdef UTMI_RX_BYTE_CNT_EN
  logic [15:0] rx_byte_count;
`endif

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  int         errors = 0;
  int         checks = 0;
  int         gap_fixed = 0;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;

  always #5 clk = ~clk;

  utmi_rx_unstuff_deser #(
    .SYNC_MIN_ZEROS (3),
    .STUFF_LEN      (6),
    .MAX_BYTES      (MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_en   (data_en),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_ACTIVE (RX_ACTIVE),
    .RX_ERROR  (RX_ERROR)
`ifdef UTMI_RX_BYTE_CNT_EN
    ,
    .rx_byte_count (rx_byte_count)
`endif
  );

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (RX_VALID || RX_ERROR) begin
      checks++;
      if (RX_VALID && RX_ERROR) begin
        errors++;
        $display("FAIL both_pulses: got valid=1 error=1, expected only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got valid=%0b error=%0b data=%02h, expected no event",
                 RX_VALID, RX_ERROR, RX_DATA);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != RX_ERROR || (!e.is_err && e.data != RX_DATA)) begin
          errors++;
          $display("FAIL event: got error=%0b data=%02h, expected error=%0b data=%02h",
                   RX_ERROR, RX_DATA, e.is_err, e.data);
        end
      end
      checks++;
      if ((RX_VALID && prev_v) || (RX_ERROR && prev_e)) begin
        errors++;
        $display("FAIL pulse_width: got pulse lasting 2+ cycles, expected 1 cycle");
      end
    end
    prev_v = RX_VALID;
    prev_e = RX_ERROR;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    int g;
    data_in = b;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    data_in = 1'($urandom);
    g = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(2, 0));
    repeat (g) @(negedge clk);
  endtask

  // Builds the unstuffed data-bit list (bytes, junk bits, EOP lead-in 0 + six 1s),
  // predicts the SIE events from byte/alignment/length rules, then transmits it stuffed.
  task automatic send_packet(input int nzeros, input int njunk);
    bit         d[$];
    logic [7:0] b;
    int         nfull;
    int         run;
    int         nidle;
    bit         babbled;
    foreach (pkt[k]) for (int i = 0; i < 8; i++) d.push_back(pkt[k][i]);
    for (int i = 0; i < njunk; i++) d.push_back(1'($urandom));
    d.push_back(1'b0);
    for (int i = 0; i < 6; i++) d.push_back(1'b1);

    nfull   = d.size() / 8;
    babbled = 1'b0;
    for (int k = 0; k < nfull && !babbled; k++) begin
      for (int i = 0; i < 8; i++) b[i] = d[8*k+i];
      if (k < MAXB) begin
        exp_q.push_back('{is_err: 1'b0, data: b});
      end else begin
        exp_q.push_back('{is_err: 1'b1, data: 8'h00});
        babbled = 1'b1;
      end
    end
    if (!babbled && (d.size() % 8) != 7) exp_q.push_back('{is_err: 1'b1, data: 8'h00});

    nidle = 2 + int'($urandom_range(3, 0));
    repeat (nidle) send_bit(1'b1);
    repeat (nzeros) send_bit(1'b0);
    send_bit(1'b1);
    chk("active_after_sync", int'(RX_ACTIVE), 1);
    run = 0;
    for (int i = 0; i < d.size(); i++) begin
      send_bit(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 6 && i != d.size() - 1) begin
        send_bit(1'b0);
        run = 0;
      end
    end
    send_bit(1'b1);
    repeat (10) send_bit(1'b1);
    chk("active_after_eop", int'(RX_ACTIVE), 0);
    chk("events_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int nj;
    rst     = 1'b1;
    data_in = 1'b1;
    data_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rx_data", int'(RX_DATA), 0);
    chk("reset_rx_valid", int'(RX_VALID), 0);
    chk("reset_rx_active", int'(RX_ACTIVE), 0);
    chk("reset_rx_error", int'(RX_ERROR), 0);
    rst = 1'b0;

    pkt = '{8'hA5};
    send_packet(7, 0);
    pkt = '{8'h3F};
    send_packet(3, 0);
    pkt.delete();
    send_packet(4, 5);
    pkt = '{8'h00, 8'h00, 8'h00};
    send_packet(3, 0);

    repeat (3) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("short_sync_no_active", int'(RX_ACTIVE), 0);
    repeat (4) send_bit(1'b1);
    gap_fixed = 1;
    pkt = '{8'h5A};
    send_packet(3, 0);
    gap_fixed = 0;

    repeat (4) send_bit(1'b1);
    repeat (3) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rx_data", int'(RX_DATA), 0);
    chk("midrst_rx_valid", int'(RX_VALID), 0);
    chk("midrst_rx_active", int'(RX_ACTIVE), 0);
    chk("midrst_rx_error", int'(RX_ERROR), 0);
    chk("midrst_no_pending", exp_q.size(), 0);
    pkt = '{8'h81};
    send_packet(3, 0);

    gap_fixed = -1;
    for (int t = 0; t < 24; t++) begin
      pkt.delete();
      n = int'($urandom_range(3, 0));
      for (int k = 0; k < n; k++) pkt.push_back(8'($urandom));
      nj = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(7, 1));
      send_packet(int'($urandom_range(8, 3)), nj);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/utmi_rx_unstuff_deser.md
Name: utmi_rx_unstuff_deser

Overview:
- Receive-path counterpart of the TX bit-stuffer/serializer. Sits between the NRZI decoder output and the RX state machine / SIE.
- Hunts for SYNC, strips stuffed bits and deserializes bytes LSB-first. Detects EOP as a bit-stuff violation.
- Raises RX_ACTIVE, RX_VALID and RX_ERROR toward the SIE, plus a babble guard on packet length.

Parameters:
- SYNC_MIN_ZEROS, 3: minimum consecutive decoded 0s before the terminating 1 that counts as SYNC.
- STUFF_LEN, 6: run of 1s after which the next bit must be a stuffed 0.
- MAX_BYTES, 1024: byte limit per packet; exceeding it is babble.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- data_in  in  1  NRZI-decoded serial bit; line idle decodes as 1.
- data_en  in  1  bit strobe; data_in is sampled only when data_en=1.
- RX_DATA  out  8  received byte, LSB = first bit received.
- RX_VALID  out  1  one-cycle pulse; RX_DATA holds a new byte.
- RX_ACTIVE  out  1  high from SYNC detection until packet end.
- RX_ERROR  out  1  one-cycle pulse on stuff, alignment or babble error.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=HUNT, all counters 0, RX_DATA=8'h00, RX_VALID=0, RX_ACTIVE=0, RX_ERROR=0. Reset mid-packet aborts the packet silently; no RX_ERROR pulse.
- Bits are processed only on cycles with data_en=1. Other cycles hold all state; pulses still last exactly one cycle.
- States: HUNT, SYNC, DATA, DONE.
- HUNT: 1s are ignored. A 0 sets zero_cnt=1 and moves to SYNC.
- SYNC:
  - A 0 increments zero_cnt, saturating at 7.
  - A 1 with zero_cnt>=SYNC_MIN_ZEROS moves to DATA and sets RX_ACTIVE=1 on the next edge. ones_cnt and bit_cnt are cleared.
  - A 1 with zero_cnt<SYNC_MIN_ZEROS returns to HUNT.
- DATA, bit b (ones_cnt counts consecutive 1s, stuffed bits included):
  - ones_cnt==STUFF_LEN and b=0: stuffed bit. Discard it, clear ones_cnt, leave bit_cnt unchanged.
  - ones_cnt==STUFF_LEN and b=1: EOP (stuff violation).
    - bit_cnt==7: normal end. The partial byte is discarded; no RX_ERROR.
    - Any other bit_cnt: RX_ERROR pulses.
    - Either case: go to DONE.
  - Otherwise: shift b into shift[7] with the register shifting right. Increment bit_cnt mod 8. ones_cnt becomes b ? ones_cnt+1 : 0.
  - When bit_cnt wraps 7->0: RX_DATA is loaded with the completed byte and RX_VALID pulses on the edge after the 8th data bit is sampled (latency 1 cycle). byte_cnt increments.
  - Babble: if a byte completes with byte_cnt==MAX_BYTES already, there is no RX_VALID. RX_ERROR pulses and the block goes to DONE.
- DONE: RX_ACTIVE deasserts on entry. The block stays in DONE until ones_cnt>=7 consecutive 1s have been seen (line idle), then returns to HUNT. This stops a babbling stream being re-synced mid-packet.
- Simultaneous events: a byte completion and an EOP cannot share a bit. RX_VALID and RX_ERROR are never high in the same cycle.
- Counters: ones_cnt is 3 bits, saturating. bit_cnt is 3 bits, wrapping. byte_cnt is $clog2(MAX_BYTES+1) bits.

Optional Feature:
- Macro: UTMI_RX_BYTE_CNT_EN.
- When defined: adds output port rx_byte_count [15:0].
  - Holds byte_cnt of the current packet.
  - Frozen at packet end until the next SYNC, which clears it to 0.
  - Reset value 0.
- When undefined: the port and its register are absent; the internal babble byte_cnt remains.

Decomposition:
- Package utmi_rx_pkg holds:
  - the state enum (HUNT, SYNC, DATA, DONE);
  - STUFF_LEN_DEF, SYNC_MIN_ZEROS_DEF, EOP_ONES=7;
  - the localparam byte width 8.
- Sub-module utmi_rx_bit_unstuffer:
  - Inputs: bit, strobe, clear. Outputs: data_bit, data_strobe, stuff_err.
  - Owns ones_cnt.
- The top-level module owns the FSM, the shifter and the counters.

Test Plan:
1. Idle 1s, then bits 0000000 1, then byte 8'hA5 (LSB-first bits 1,0,1,0,0,1,0,1), then EOP bits 0,1,1,1,1,1,1,1 -> RX_ACTIVE rises after SYNC; exactly one RX_VALID with RX_DATA=8'hA5; RX_ACTIVE falls; RX_ERROR never high.
2. SYNC, then byte 8'h3F sent as 1,1,1,1,1,1,[stuffed 0],0,0, then EOP -> RX_DATA=8'h3F, stuffed bit removed, no error.
3. SYNC, then 5 data bits, then seven 1s -> RX_ERROR single pulse, no RX_VALID, RX_ACTIVE falls, state returns to HUNT after idle.
4. MAX_BYTES=2, SYNC plus three 8'h00 bytes -> two RX_VALID pulses, then RX_ERROR on the third byte completion, RX_ACTIVE low.
5. SYNC with only two 0s (00 1) -> no RX_ACTIVE. Then 0001 plus 8'h5A with data_en toggling every other cycle -> RX_DATA=8'h5A.
6. rst asserted mid-byte of packet 8'hC3 -> all outputs 0 next edge, no RX_ERROR; a following packet 8'h81 is received correctly.
